// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage and producer side of the instruction queue.
// Holds the fetch PC, issues one-word reads with at most one request outstanding,
// pushes each returned word into enqueue lane 0, and squashes the in-flight
// response when the back end redirects the fetch stream.

package fetch_pkg;

    // One instruction-queue entry as produced by the fetch stage.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

endpackage : fetch_pkg

module fetch_unit #(
    parameter int          NSIZE      = 1,
    parameter int          DEPTH_BITS = 8,
    parameter logic [31:0] RESET_PC   = 32'h1eceb000
) (
    input  logic                                clk,
    input  logic                                rst,

    output logic [31:0]                         imem_addr,
    output logic [3:0]                          imem_rmask,
    input  logic [31:0]                         imem_rdata,
    input  logic                                imem_resp,

    input  logic [DEPTH_BITS:0]                 iq_freespace,
    output fetch_pkg::iq_entry_t [NSIZE-1:0]    iq_din,
    output logic [NSIZE-1:0]                    iq_enqueue,

    input  logic                                redirect_valid,
    input  logic [31:0]                         redirect_pc
);

    localparam int FW = DEPTH_BITS + 1;

    // IDLE: nothing outstanding. WAIT: a live request is outstanding.
    // DROP: the outstanding request belongs to a squashed path.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] req_pc, req_pc_next;

    logic        enq_now;
    logic        can_issue;
    logic        issue;
    logic [FW-1:0] need;
    logic [31:0] redirect_aligned;

    // Redirect targets are always word aligned; the low two bits are dropped.
    assign redirect_aligned = redirect_pc & 32'hffff_fffc;

    // A live response is pushed unless a redirect squashes it in the same cycle.
    assign enq_now = !rst && imem_resp && (state == S_WAIT) && !redirect_valid;

    // Reserve one slot for the new request on top of the slot consumed this cycle,
    // so the eventual push of the new request can never overflow the queue.
    assign need      = FW'(1) + FW'(enq_now);
    assign can_issue = (iq_freespace >= need);

    // State, fetch PC and outstanding-request PC registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values computed by the combinational block.
        if (rst) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            req_pc <= req_pc_next;
        end
    end

    // Next-state decode: redirect first, then response handling, then issue.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_next  = state;
        pc_next     = pc;
        req_pc_next = req_pc;
        issue       = 1'b0;

        case (state)
            S_IDLE: begin
                // A response arriving here has no owner and is ignored.
                if (redirect_valid) begin
                    pc_next = redirect_aligned;
                end else if (can_issue) begin
                    issue      = 1'b1;
                    state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_next    = redirect_aligned;
                    state_next = imem_resp ? S_IDLE : S_DROP;
                end else if (imem_resp) begin
                    // The response is pushed (enq_now); chain the next request
                    // into the same cycle when space allows.
                    if (can_issue) begin
                        issue      = 1'b1;
                        state_next = S_WAIT;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end

            S_DROP: begin
                if (redirect_valid) begin
                    pc_next    = redirect_aligned;
                    state_next = imem_resp ? S_IDLE : S_DROP;
                end else if (imem_resp) begin
                    // Stale response retires the old request without a push.
                    if (can_issue) begin
                        issue      = 1'b1;
                        state_next = S_WAIT;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Reset suppresses any issue so outputs stay quiet while rst is high.
        if (rst) begin
            issue = 1'b0;
        end

        if (issue) begin
            req_pc_next = pc;
            pc_next     = pc + 32'd4;
        end
    end

    // Memory request and queue push outputs.
    always_comb begin
        imem_addr  = pc;
        imem_rmask = issue ? 4'hf : 4'h0;

        iq_din     = '0;
        iq_enqueue = '0;
        iq_enqueue[0] = enq_now;
        if (enq_now) begin
            iq_din[0].pc   = req_pc;
            iq_din[0].inst = imem_rdata;
        end
    end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit. Inputs are driven
// shortly after each rising edge and outputs are sampled before the next one.

module tb_fetch_unit;

    localparam int NSIZE      = 1;
    localparam int DEPTH_BITS = 8;
    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    logic                             clk;
    logic                             rst;
    logic [31:0]                      imem_addr;
    logic [3:0]                       imem_rmask;
    logic [31:0]                      imem_rdata;
    logic                             imem_resp;
    logic [DEPTH_BITS:0]              iq_freespace;
    fetch_pkg::iq_entry_t [NSIZE-1:0] iq_din;
    logic [NSIZE-1:0]                 iq_enqueue;
    logic                             redirect_valid;
    logic [31:0]                      redirect_pc;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_unit #(
        .NSIZE      (NSIZE),
        .DEPTH_BITS (DEPTH_BITS),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .iq_freespace   (iq_freespace),
        .iq_din         (iq_din),
        .iq_enqueue     (iq_enqueue),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs and let combinational outputs settle.
    task automatic drive(input logic resp, input logic [31:0] rdata,
                         input logic redir, input logic [31:0] rpc,
                         input logic [DEPTH_BITS:0] fs);
        imem_resp      = resp;
        imem_rdata     = rdata;
        redirect_valid = redir;
        redirect_pc    = rpc;
        iq_freespace   = fs;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check a cycle that issues a request to addr with no push.
    task automatic chk_issue(input string tag, input logic [31:0] addr);
        chk({tag, "_rmask"}, 32'(imem_rmask), 32'hf);
        chk({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic chk_noissue(input string tag);
        chk({tag, "_rmask"}, 32'(imem_rmask), 32'h0);
    endtask

    task automatic chk_enq(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, "_enq"}, 32'(iq_enqueue), 32'h1);
        chk({tag, "_pc"}, iq_din[0].pc, pc);
        chk({tag, "_inst"}, iq_din[0].inst, inst);
    endtask

    task automatic chk_noenq(input string tag);
        chk({tag, "_enq"}, 32'(iq_enqueue), 32'h0);
        chk({tag, "_din"}, iq_din[0].pc | iq_din[0].inst, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 9'd256);
        step();

        // Reset values while rst is still high.
        drive(1'b1, 32'hdeadbeef, 1'b0, 32'h0, 9'd256);
        chk_noissue("rst");
        chk_noenq("rst");
        chk("rst_addr", imem_addr, RESET_PC);
        step();

        // Stream: first request in the first cycle out of reset.
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 9'd256);
        chk_issue("s0", 32'h1eceb000);
        chk_noenq("s0");
        step();
        // Response plus same-cycle reissue.
        drive(1'b1, 32'h11111111, 1'b0, 32'h0, 9'd256);
        chk_enq("s1", 32'h1eceb000, 32'h11111111);
        chk_issue("s1", 32'h1eceb004);
        step();
        // Waiting, nothing happens.
        drive(1'b0, 32'h0, 1'b0, 32'h0, 9'd256);
        chk_noissue("s2");
        chk_noenq("s2");
        step();
        drive(1'b1, 32'h22222222, 1'b0, 32'h0, 9'd256);
        chk_enq("s3", 32'h1eceb004, 32'h22222222);
        chk_issue("s3", 32'h1eceb008);
        step();

        // Freespace 1 at the response: push but no reissue.
        drive(1'b1, 32'h33333333, 1'b0, 32'h0, 9'd1);
        chk_enq("fs1", 32'h1eceb008, 32'h33333333);
        chk_noissue("fs1");
        step();
        // Queue full for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 9'd0);
            chk_noissue("full");
            step();
        end
        // Space appears: issue immediately.
        drive(1'b0, 32'h0, 1'b0, 32'h0, 9'd1);
        chk_issue("resume", 32'h1eceb00c);
        step();

        // Redirect in WAIT without resp -> DROP; stale response 3 cycles later.
        drive(1'b0, 32'h0, 1'b1, 32'h1eceb100, 9'd256);
        chk_noissue("rw0");
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 9'd256);
        chk_noissue("rw1");
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 9'd256);
        chk_noissue("rw2");
        step();
        drive(1'b1, 32'h44444444, 1'b0, 32'h0, 9'd256);
        chk_noenq("rw3");
        chk_issue("rw3", 32'h1eceb100);
        step();

        // Redirect coincident with response: dropped, new PC next cycle.
        drive(1'b1, 32'h55555555, 1'b1, 32'h1eceb180, 9'd256);
        chk_noenq("rr0");
        chk_noissue("rr0");
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 9'd256);
        chk_issue("rr1", 32'h1eceb180);
        step();

        // Two redirects while a stale request is outstanding; the newest wins.
        drive(1'b0, 32'h0, 1'b1, 32'h00000200, 9'd256);
        chk_noissue("dd0");
        step();
        drive(1'b0, 32'h0, 1'b1, 32'h00000300, 9'd256);
        chk_noissue("dd1");
        chk_noenq("dd1");
        step();
        drive(1'b1, 32'h99999999, 1'b0, 32'h0, 9'd256);
        chk_noenq("dd2");
        chk_issue("dd2", 32'h00000300);
        step();
        drive(1'b1, 32'h66666666, 1'b0, 32'h0, 9'd256);
        chk_enq("dd3", 32'h00000300, 32'h66666666);
        chk_issue("dd3", 32'h00000304);
        step();

        // Wrap at the top of the address space.
        drive(1'b1, 32'haaaaaaaa, 1'b1, 32'hfffffffc, 9'd256);
        chk_noenq("wr0");
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 9'd256);
        chk_issue("wr1", 32'hfffffffc);
        step();
        drive(1'b1, 32'h77777777, 1'b0, 32'h0, 9'd256);
        chk_enq("wr2", 32'hfffffffc, 32'h77777777);
        chk_issue("wr2", 32'h00000000);
        step();

        // Misaligned redirect target is forced to a word boundary.
        drive(1'b1, 32'hbbbbbbbb, 1'b1, 32'h1eceb102, 9'd256);
        chk_noenq("al0");
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 9'd256);
        chk_issue("al1", 32'h1eceb100);
        step();

        // Reset with a request outstanding; the later response is ignored.
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 9'd256);
        chk_noissue("mr0");
        step();
        rst = 1'b0;
        drive(1'b1, 32'hcccccccc, 1'b0, 32'h0, 9'd0);
        chk_noenq("mr1");
        chk_noissue("mr1");
        chk("mr1_addr", imem_addr, RESET_PC);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 9'd1);
        chk_issue("mr2", RESET_PC);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
# fetch_unit

Front-end instruction fetch stage and the producer side of the instruction queue. It holds the fetch PC, issues one-word read requests to the instruction memory/cache port, and pushes each returned instruction into the queue's enqueue lanes, using the queue's `freespace` as its only flow-control credit. It accepts a redirect (mispredict/exception target) from the back end and discards any in-flight response that belongs to the squashed path.

## Interface
- `NSIZE`, 1: width of the queue's enqueue port; only lane 0 is ever driven valid.
- `DEPTH_BITS`, 8: matches the queue; sets the `freespace` width.
- `RESET_PC`, 32'h1eceb000: first fetch address after reset.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  request address, word aligned.
- `imem_rmask`  out  4  4'b1111 in an issue cycle, else 4'b0000.
- `imem_rdata`  in  32  instruction word, valid only when `imem_resp`.
- `imem_resp`  in  1  one-cycle response pulse for the single outstanding request.
- `iq_freespace`  in  DEPTH_BITS+1  queue free slots, from registered queue state.
- `iq_din`  out  iq_entry_t[NSIZE]  lane 0: `.pc` = request PC, `.inst` = `imem_rdata`; every other field and lane is '0.
- `iq_enqueue`  out  NSIZE  bit 0 = push lane 0 this cycle; other bits 0.
- `redirect_valid`  in  1  load a new fetch PC.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored and forced to 0.

## Operation
- Registers: `pc` (next address to request), `req_pc` (address of outstanding request), `state`.
- At most one outstanding request. No branch prediction: after an issue, `pc` <= `pc` + 4, wrapping modulo 2^32.
- `enq_now` = `imem_resp` && state==WAIT && !`redirect_valid`; `iq_enqueue[0]` = `enq_now`.
- `can_issue` = `iq_freespace` >= 1 + `enq_now`, compared at DEPTH_BITS+1 bits. Space is reserved at issue time, so the eventual enqueue never overflows, because dequeues only add space.
- Issue means `imem_addr` = `pc`, `imem_rmask` = 4'hf, `req_pc` <= `pc`, `pc` <= `pc` + 4. When not issuing, `imem_addr` = `pc` and `imem_rmask` = 0.
- IDLE, no request outstanding:
  - redirect: `pc` <= `redirect_pc`; no issue; stay IDLE.
  - else if `can_issue`: issue; go to WAIT.
  - `imem_resp` in IDLE is ignored.
- WAIT, live request outstanding:
  - redirect with resp: drop the response; `pc` <= `redirect_pc`; go to IDLE.
  - redirect without resp: `pc` <= `redirect_pc`; go to DROP.
  - resp without redirect: enqueue {`req_pc`, `imem_rdata`}. If `can_issue`, issue in the same cycle and stay WAIT; else go to IDLE.
- DROP, stale request outstanding:
  - redirect: `pc` <= `redirect_pc`. If resp, go to IDLE; else stay DROP.
  - resp without redirect: no enqueue. If `can_issue`, issue and go to WAIT; else go to IDLE.
- Redirect always wins over issue in the same cycle. The newest redirect overwrites `pc`.

## Timing
- Reset values: state IDLE, `pc` = RESET_PC, `req_pc` = 0. All outputs at reset: `imem_rmask` = 0, `iq_enqueue` = 0, `iq_din` = '0, `imem_addr` = RESET_PC.
- First request is issued in the first cycle with `rst` low, provided `iq_freespace` >= 1.
- Request to enqueue: `iq_enqueue` is asserted combinationally in the `imem_resp` cycle. The entry is visible in the queue the next cycle.
- Back-to-back throughput is one instruction per memory round trip. The response and the next issue share a cycle, so `imem_resp` combinationally feeds `imem_rmask` and `iq_enqueue`.
- Redirect latency: redirect in cycle t (IDLE, or WAIT with resp) gives a request to `redirect_pc` in t+1 if `can_issue`. Redirect in WAIT without resp waits for the stale response in DROP, then issues in that response cycle.
- Queue full (`iq_freespace` = 0): no issue, state holds IDLE. Issue resumes the cycle `iq_freespace` >= 1.
- `rst` mid-request: state returns to IDLE and any later response is ignored. Memory-side reset is the memory's responsibility.

## Test plan
- Reset, freespace 256, memory with 1-cycle latency -> requests at 0x1eceb000, …004, …008 every other cycle. Enqueued `.pc` values match, `.inst` = returned data.
- freespace held 0 for 5 cycles, then 1 -> no `imem_rmask` while 0. One request the cycle it becomes 1. With freespace 1 at the response cycle, no same-cycle reissue.
- Redirect to 0x1eceb100 while in WAIT, response 3 cycles later -> that response is not enqueued. Next request is to 0x1eceb100 in the response cycle.
- Redirect coincident with `imem_resp` -> no enqueue. Request to the new PC the next cycle.
- Two redirects in DROP (0x200, then 0x300) before the response -> the only next request is to 0x300.
- Redirect to 0xfffffffc -> requests 0xfffffffc, then 0x00000000. `redirect_pc` 0x1eceb102 -> request 0x1eceb100.
